// File: rtl/decryption_sequencer.sv
// AES inverse-cipher round controller.
// Steps one state block through external InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns units.
module decryption_sequencer #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [127:0] in_data,
   output logic         in_ready,
   output logic [127:0] step_in,
   input  logic [127:0] isr_out,
   input  logic [127:0] isb_out,
   input  logic [127:0] ark_out,
   input  logic [127:0] imc_out,
   output logic [3:0]   round_key_sel,
   output logic         out_valid,
   output logic [127:0] out_data,
   input  logic         out_ready,
   output logic         busy
);

   typedef enum logic [3:0] {
      IDLE,
      INIT_ARK,
      ISR,
      ISB,
      ARK,
      IMC,
      FIN_ISR,
      FIN_ISB,
      FIN_ARK,
      DONE
   } state_t;

   localparam logic [3:0] NR_K  = 4'(NR);
   localparam logic [3:0] NR_M1 = 4'(NR - 1);

   state_t       fsm;
   logic [127:0] st;
   logic [3:0]   rnd;

   // Sequencer: outputs are registered alongside the state they belong to
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm           <= IDLE;
         st            <= '0;
         rnd           <= '0;
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         busy          <= 1'b0;
         round_key_sel <= '0;
      end else begin
         in_ready      <= 1'b0;
         out_valid     <= 1'b0;
         busy          <= 1'b1;
         round_key_sel <= '0;
         unique case (fsm)
            IDLE: begin
               if (in_valid) begin
                  st            <= in_data;
                  rnd           <= NR_M1;
                  round_key_sel <= NR_K;
                  fsm           <= INIT_ARK;
               end else begin
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end
            end
            INIT_ARK: begin
               st  <= ark_out;
               fsm <= ISR;
            end
            ISR: begin
               st  <= isr_out;
               fsm <= ISB;
            end
            ISB: begin
               st            <= isb_out;
               round_key_sel <= rnd;
               fsm           <= ARK;
            end
            ARK: begin
               st  <= ark_out;
               fsm <= IMC;
            end
            IMC: begin
               st <= imc_out;
               if (rnd <= 4'd1) begin
                  fsm <= FIN_ISR;
               end else begin
                  rnd <= rnd - 4'd1;
                  fsm <= ISR;
               end
            end
            FIN_ISR: begin
               st  <= isr_out;
               fsm <= FIN_ISB;
            end
            FIN_ISB: begin
               st  <= isb_out;
               fsm <= FIN_ARK;
            end
            FIN_ARK: begin
               st        <= ark_out;
               out_valid <= 1'b1;
               fsm       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  fsm      <= IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: begin
               fsm <= IDLE;
            end
         endcase
      end
   end

   assign step_in  = st;
   assign out_data = st;

endmodule
